// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bundle: EX-side operands/controls, hazard controls, and the MEM-side outputs.
// The master modport is the EX/hazard side; the slave modport is the pipeline register.
interface ex_mem_stage_if #(
    parameter int TAKEN_CNT_W = 16
);
    logic                   Stall;
    logic                   Flush;
    logic [31:0]            EX_ALUResult;
    logic                   EX_Zero;
    logic [31:0]            EX_BranchTarget;
    logic [31:0]            EX_RtData;
    logic [4:0]             EX_WriteReg;
    logic                   EX_RegWrite;
    logic                   EX_MemRead;
    logic                   EX_MemWrite;
    logic                   EX_MemToReg;
    logic                   EX_Branch;
    logic                   EX_Valid;
    logic [1:0]             EX_MemSize;

    logic [31:0]            MEM_ALUResult;
    logic [31:0]            MEM_BranchTarget;
    logic [4:0]             MEM_WriteReg;
    logic                   MEM_MemToReg;
    logic [1:0]             MEM_MemSize;
    logic                   MEM_RegWrite;
    logic                   MEM_MemRead;
    logic                   MEM_MemWrite;
    logic                   MEM_Valid;
    logic [31:0]            MEM_StoreData;
    logic [3:0]             MEM_ByteEn;
    logic                   MEM_Misaligned;
    logic                   MEM_PCSrc;
    logic [TAKEN_CNT_W-1:0] TakenCount;

    modport master (
        output Stall, Flush, EX_ALUResult, EX_Zero, EX_BranchTarget, EX_RtData,
               EX_WriteReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
               EX_Branch, EX_Valid, EX_MemSize,
        input  MEM_ALUResult, MEM_BranchTarget, MEM_WriteReg, MEM_MemToReg,
               MEM_MemSize, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_Valid,
               MEM_StoreData, MEM_ByteEn, MEM_Misaligned, MEM_PCSrc, TakenCount
    );

    modport slave (
        input  Stall, Flush, EX_ALUResult, EX_Zero, EX_BranchTarget, EX_RtData,
               EX_WriteReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
               EX_Branch, EX_Valid, EX_MemSize,
        output MEM_ALUResult, MEM_BranchTarget, MEM_WriteReg, MEM_MemToReg,
               MEM_MemSize, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_Valid,
               MEM_StoreData, MEM_ByteEn, MEM_Misaligned, MEM_PCSrc, TakenCount
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with store lane formatting, byte enables and branch resolve.
// Latency 1 cycle; Stall holds all state (counter included), Flush loads a bubble and wins over Stall.
module ex_mem_stage #(
    parameter int TAKEN_CNT_W = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    ex_mem_stage_if.slave bus
);
    logic [31:0]            alu_q;
    logic [31:0]            target_q;
    logic [31:0]            rt_q;
    logic [4:0]             wreg_q;
    logic [1:0]             size_q;
    logic                   zero_q;
    logic                   regwrite_q;
    logic                   memread_q;
    logic                   memwrite_q;
    logic                   memtoreg_q;
    logic                   branch_q;
    logic                   valid_q;
    logic [TAKEN_CNT_W-1:0] taken_q;

    logic [1:0]  a;
    logic        addr_bad;
    logic        misaligned;
    logic        mem_rd;
    logic        mem_wr;
    logic        pc_src;
    logic [3:0]  byte_en;
    logic [31:0] store_dat;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            alu_q      <= '0;
            target_q   <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            size_q     <= '0;
            zero_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            branch_q   <= 1'b0;
            valid_q    <= 1'b0;
            taken_q    <= '0;
        end else begin
            // Data fields are left untouched by a flush; only controls become a bubble.
            if (bus.Flush) begin
                regwrite_q <= 1'b0;
                memread_q  <= 1'b0;
                memwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
                branch_q   <= 1'b0;
                valid_q    <= 1'b0;
            end else if (!bus.Stall) begin
                alu_q      <= bus.EX_ALUResult;
                target_q   <= bus.EX_BranchTarget;
                rt_q       <= bus.EX_RtData;
                wreg_q     <= bus.EX_WriteReg;
                size_q     <= bus.EX_MemSize;
                zero_q     <= bus.EX_Zero;
                regwrite_q <= bus.EX_RegWrite;
                memread_q  <= bus.EX_MemRead;
                memwrite_q <= bus.EX_MemWrite;
                memtoreg_q <= bus.EX_MemToReg;
                branch_q   <= bus.EX_Branch;
                valid_q    <= bus.EX_Valid;
            end
            if (pc_src && !bus.Stall && (taken_q != '1))
                taken_q <= taken_q + {{(TAKEN_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign a = alu_q[1:0];

    always_comb begin
        case (size_q)
            2'b01:   addr_bad = a[0];
            2'b10:   addr_bad = 1'b0;
            default: addr_bad = |a;
        endcase
    end

    assign misaligned = valid_q & (memread_q | memwrite_q) & addr_bad;
    assign mem_rd     = memread_q & valid_q & ~misaligned;
    assign mem_wr     = memwrite_q & valid_q & ~misaligned;
    assign pc_src     = valid_q & branch_q & zero_q;

    always_comb begin
        byte_en = 4'b0000;
        if (mem_wr) begin
            case (size_q)
                2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
                2'b10:   byte_en = 4'b0001 << a;
                default: byte_en = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (size_q)
            2'b01:   store_dat = {rt_q[15:0], rt_q[15:0]};
            2'b10:   store_dat = {4{rt_q[7:0]}};
            default: store_dat = rt_q;
        endcase
    end

    assign bus.MEM_ALUResult    = alu_q;
    assign bus.MEM_BranchTarget = target_q;
    assign bus.MEM_WriteReg     = wreg_q;
    assign bus.MEM_MemToReg     = memtoreg_q;
    assign bus.MEM_MemSize      = size_q;
    assign bus.MEM_Valid        = valid_q;
    assign bus.MEM_MemRead      = mem_rd;
    assign bus.MEM_MemWrite     = mem_wr;
    assign bus.MEM_RegWrite     = regwrite_q & valid_q & ~(memread_q & misaligned);
    assign bus.MEM_Misaligned   = misaligned;
    assign bus.MEM_ByteEn       = byte_en;
    assign bus.MEM_StoreData    = store_dat;
    assign bus.MEM_PCSrc        = pc_src;
    assign bus.TakenCount       = taken_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a reference model predicts MEM outputs per edge into a
// scoreboard queue that is drained after each edge, plus directed checks on the corner cases.
module tb_ex_mem_stage;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    ex_mem_stage_if #(.TAKEN_CNT_W(CW)) bus ();

    ex_mem_stage #(.TAKEN_CNT_W(CW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] bt;
        logic [31:0] rt;
        logic        zero;
        logic [4:0]  wreg;
        logic        rw;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        br;
        logic        vld;
        logic [1:0]  size;
    } ex_t;

    typedef struct packed {
        bit          known;
        logic [31:0] alu;
        logic [31:0] bt;
        logic [4:0]  wreg;
        logic        m2r;
        logic [1:0]  size;
        logic        rw;
        logic        rd;
        logic        wr;
        logic        vld;
        logic [31:0] sd;
        logic [3:0]  be;
        logic        mis;
        logic        pcs;
        logic [CW-1:0] cnt;
    } exp_t;

    ex_t         st;
    bit          st_known;
    logic [CW-1:0] st_cnt;
    exp_t        sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t predict(input ex_t s, input logic [CW-1:0] cnt, input bit known);
        exp_t e;
        logic [1:0] a;
        bit half, byt, word, bad;
        e = '0;
        a = s.alu[1:0];
        half = (s.size == 2'd1);
        byt  = (s.size == 2'd2);
        word = !half && !byt;
        bad  = word ? (a != 2'd0) : (half ? a[0] : 1'b0);
        e.mis = s.vld && (s.rd || s.wr) && bad;
        e.rd  = s.vld && s.rd && !e.mis;
        e.wr  = s.vld && s.wr && !e.mis;
        e.rw  = s.vld && s.rw && !(s.rd && e.mis);
        for (int i = 0; i < 4; i++) begin
            e.be[i] = e.wr && (word || (half && ((i / 2) == int'(a[1]))) || (byt && (i == int'(a))));
            e.sd[8*i +: 8] = word ? s.rt[8*i +: 8] : (half ? s.rt[8*(i%2) +: 8] : s.rt[7:0]);
        end
        e.pcs   = s.vld && s.br && s.zero;
        e.alu   = s.alu;
        e.bt    = s.bt;
        e.wreg  = s.wreg;
        e.m2r   = s.m2r;
        e.size  = s.size;
        e.vld   = s.vld;
        e.cnt   = cnt;
        e.known = known;
        return e;
    endfunction

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_eq("rw",   bus.MEM_RegWrite,   e.rw);
        check_eq("rd",   bus.MEM_MemRead,    e.rd);
        check_eq("wr",   bus.MEM_MemWrite,   e.wr);
        check_eq("m2r",  bus.MEM_MemToReg,   e.m2r);
        check_eq("vld",  bus.MEM_Valid,      e.vld);
        check_eq("be",   bus.MEM_ByteEn,     e.be);
        check_eq("mis",  bus.MEM_Misaligned, e.mis);
        check_eq("pcs",  bus.MEM_PCSrc,      e.pcs);
        check_eq("cnt",  bus.TakenCount,     e.cnt);
        if (e.known) begin
            check_eq("alu",  bus.MEM_ALUResult,    e.alu);
            check_eq("bt",   bus.MEM_BranchTarget, e.bt);
            check_eq("wreg", bus.MEM_WriteReg,     e.wreg);
            check_eq("size", bus.MEM_MemSize,      e.size);
            check_eq("sd",   bus.MEM_StoreData,    e.sd);
        end
    endtask

    // Called at a negedge: drive, advance the model across the next posedge, then compare.
    task automatic step(input ex_t x, input bit stall, input bit flush);
        bit pcs_old;
        bus.EX_ALUResult    = x.alu;
        bus.EX_BranchTarget = x.bt;
        bus.EX_RtData       = x.rt;
        bus.EX_Zero         = x.zero;
        bus.EX_WriteReg     = x.wreg;
        bus.EX_RegWrite     = x.rw;
        bus.EX_MemRead      = x.rd;
        bus.EX_MemWrite     = x.wr;
        bus.EX_MemToReg     = x.m2r;
        bus.EX_Branch       = x.br;
        bus.EX_Valid        = x.vld;
        bus.EX_MemSize      = x.size;
        bus.Stall           = stall;
        bus.Flush           = flush;
        pcs_old = st.vld && st.br && st.zero;
        if (pcs_old && !stall && (st_cnt != {CW{1'b1}})) st_cnt = st_cnt + 1'b1;
        if (flush) begin
            st.rw = 0; st.rd = 0; st.wr = 0; st.m2r = 0; st.br = 0; st.vld = 0;
            st_known = 0;
        end else if (!stall) begin
            st = x;
            st_known = 1;
        end
        sb.push_back(predict(st, st_cnt, st_known));
        @(posedge clk);
        @(negedge clk);
        compare_front();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_alu"}, bus.MEM_ALUResult, 32'd0);
        check_eq({tag, "_bt"},  bus.MEM_BranchTarget, 32'd0);
        check_eq({tag, "_ctl"}, {bus.MEM_RegWrite, bus.MEM_MemRead, bus.MEM_MemWrite,
                                 bus.MEM_MemToReg, bus.MEM_Valid, bus.MEM_WriteReg, bus.MEM_MemSize}, 32'd0);
        check_eq({tag, "_sd"},  bus.MEM_StoreData, 32'd0);
        check_eq({tag, "_be"},  bus.MEM_ByteEn, 32'd0);
        check_eq({tag, "_mis"}, bus.MEM_Misaligned, 32'd0);
        check_eq({tag, "_pcs"}, bus.MEM_PCSrc, 32'd0);
        check_eq({tag, "_cnt"}, bus.TakenCount, 32'd0);
    endtask

    function automatic ex_t rand_ex();
        ex_t x;
        x.alu  = $urandom;
        x.bt   = $urandom;
        x.rt   = $urandom;
        x.zero = 1'($urandom_range(0, 1));
        x.wreg = 5'($urandom_range(0, 31));
        x.rw   = 1'($urandom_range(0, 1));
        x.rd   = 1'($urandom_range(0, 1));
        x.wr   = 1'($urandom_range(0, 1));
        x.m2r  = 1'($urandom_range(0, 1));
        x.br   = 1'($urandom_range(0, 1));
        x.vld  = ($urandom_range(0, 7) != 0);
        x.size = 2'($urandom_range(0, 3));
        return x;
    endfunction

    ex_t x;
    ex_t nop;

    initial begin
        n_checks = 0;
        n_err    = 0;
        nop      = '0;
        st       = '0;
        st_known = 1;
        st_cnt   = '0;
        rst      = 1'b1;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        bus.EX_ALUResult = '0; bus.EX_BranchTarget = '0; bus.EX_RtData = '0;
        bus.EX_Zero = 1'b0; bus.EX_WriteReg = '0; bus.EX_RegWrite = 1'b0;
        bus.EX_MemRead = 1'b0; bus.EX_MemWrite = 1'b0; bus.EX_MemToReg = 1'b0;
        bus.EX_Branch = 1'b0; bus.EX_Valid = 1'b0; bus.EX_MemSize = '0;

        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Byte store to lane 3
        x = '0; x.alu = 32'h1003; x.size = 2'b10; x.wr = 1; x.rt = 32'hAABBCCDD; x.vld = 1;
        step(x, 0, 0);
        check_eq("bstore_be",  bus.MEM_ByteEn, 32'b1000);
        check_eq("bstore_sd",  bus.MEM_StoreData, 32'hDDDDDDDD);
        check_eq("bstore_mis", bus.MEM_Misaligned, 32'd0);

        // Misaligned word load
        x = '0; x.alu = 32'h1002; x.size = 2'b00; x.rd = 1; x.rw = 1; x.vld = 1; x.wreg = 5'd9;
        step(x, 0, 0);
        check_eq("mload_mis", bus.MEM_Misaligned, 32'd1);
        check_eq("mload_rd",  bus.MEM_MemRead, 32'd0);
        check_eq("mload_rw",  bus.MEM_RegWrite, 32'd0);
        check_eq("mload_be",  bus.MEM_ByteEn, 32'd0);

        // Taken branch held under stall, counted once on release, then flush+stall
        x = '0; x.br = 1; x.zero = 1; x.vld = 1; x.bt = 32'h0000_4000;
        step(x, 0, 0);
        check_eq("br_pcs", bus.MEM_PCSrc, 32'd1);
        check_eq("br_cnt", bus.TakenCount, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(rand_ex(), 1, 0);
            check_eq("stall_pcs", bus.MEM_PCSrc, 32'd1);
            check_eq("stall_cnt", bus.TakenCount, 32'd0);
        end
        step(x, 0, 0);
        check_eq("release_cnt", bus.TakenCount, 32'd1);
        step(x, 1, 1);
        check_eq("flush_vld", bus.MEM_Valid, 32'd0);
        check_eq("flush_pcs", bus.MEM_PCSrc, 32'd0);
        check_eq("flush_cnt", bus.TakenCount, 32'd1);

        // Not-taken branch leaves the count alone
        x.zero = 0;
        step(x, 0, 0);
        check_eq("nt_pcs", bus.MEM_PCSrc, 32'd0);
        step(nop, 0, 0);
        check_eq("nt_cnt", bus.TakenCount, 32'd1);

        // Back-to-back taken branches count once each
        x.zero = 1;
        step(x, 0, 0);
        step(x, 0, 0);
        step(nop, 0, 0);
        check_eq("b2b_cnt", bus.TakenCount, 32'd3);

        // Random traffic with stalls and flushes
        for (int i = 0; i < 300; i++)
            step(rand_ex(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));

        // Asynchronous reset mid-stream, observed before the next rising edge
        step(x, 0, 0);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        st = '0; st_known = 1; st_cnt = '0;
        @(negedge clk);
        rst = 1'b0;

        // 17 taken branches saturate a 4-bit counter
        for (int i = 0; i < 17; i++) step(x, 0, 0);
        step(nop, 0, 0);
        check_eq("sat_cnt", bus.TakenCount, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage for the 5-stage MIPS datapath. Registers the ALU result, the branch flag (Zero), the branch target and the store operand at the end of EX, with stall (hold) and flush (bubble) control. Converts the registered operation size into data-memory byte enables and lane-replicated store data. Resolves branches one cycle after EX and drives the PC select.

## Interface
- `TAKEN_CNT_W`, default 16: width of the saturating taken-branch counter.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high; clears all state.
- `Stall` in 1: hold every register.
- `Flush` in 1: load a bubble instead of the EX inputs.
- `EX_ALUResult` in 32: ALU result (address for loads and stores).
- `EX_Zero` in 1: ALU branch-condition flag; 1 means the condition is true.
- `EX_BranchTarget` in 32: computed branch target.
- `EX_RtData` in 32: store operand.
- `EX_WriteReg` in 5: destination register.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemWrite`, `EX_MemToReg`, `EX_Branch`, `EX_Valid` in 1 each: control bits.
- `EX_MemSize` in 2: 00 word, 01 half, 10 byte, 11 treated as word.
- `MEM_ALUResult` out 32, `MEM_BranchTarget` out 32, `MEM_WriteReg` out 5, `MEM_MemToReg` out 1, `MEM_MemSize` out 2: registered copies.
- `MEM_RegWrite`, `MEM_MemRead`, `MEM_MemWrite`, `MEM_Valid` out 1 each: registered controls, qualified as described under Operation.
- `MEM_StoreData` out 32: store operand replicated across lanes.
- `MEM_ByteEn` out 4: data-memory byte enables.
- `MEM_Misaligned` out 1: alignment fault on the access held in MEM.
- `MEM_PCSrc` out 1: take the branch.
- `TakenCount` out `TAKEN_CNT_W`: count of taken branches.

## Operation
- **Register update**, per rising edge, priority Reset > Flush > Stall > load.
  - Flush: all control bits and `Valid` are cleared; the data registers may keep any value.
  - Stall: every register, including `TakenCount`, holds.
  - Flush takes priority over Stall when both are asserted.
- **Alignment** uses `a = MEM_ALUResult[1:0]`.
  - Word: `a` must be 00.
  - Half: `a[0]` must be 0.
  - Byte: always aligned.
  - `MEM_Misaligned` = `Valid` & (`MemRead` | `MemWrite`) & misaligned.
- **Qualified outputs**, where `raw` means the registered EX control bit:
  - `MEM_MemRead` = raw & `Valid` & !`Misaligned`.
  - `MEM_MemWrite` = raw & `Valid` & !`Misaligned`.
  - `MEM_RegWrite` = raw & `Valid` & !(raw `MemRead` & `Misaligned`).
- **Byte enables** (little-endian), all 0 unless `MEM_MemWrite`:
  - Word: 1111.
  - Half: 0011 for `a`=00, 1100 for `a`=10.
  - Byte: 0001 shifted left by `a`.
- **Store data**, from the registered `RtData`:
  - Word: `RtData`.
  - Half: {`RtData[15:0]`, `RtData[15:0]`}.
  - Byte: `RtData[7:0]` repeated four times.
- **Branch**: `MEM_PCSrc` = `Valid` & `Branch` & `Zero` (combinational from registers).
- **TakenCount**: increments on each clock edge where `MEM_PCSrc` = 1 and `Stall` = 0; saturates at all-ones and does not wrap.
- **Upstream squash**: the hazard unit asserts `Flush` on the cycle after `MEM_PCSrc` rises. The block does not self-flush.

## Timing
- Latency: one cycle from EX inputs to MEM outputs. All other MEM outputs are combinational from the registered state, with no further delay.
- Reset values:
  - All registered fields are 0.
  - Derived outputs: `MEM_ByteEn` = 0000, `MEM_PCSrc` = 0, `MEM_Misaligned` = 0, `TakenCount` = 0.
  - `MEM_StoreData` = 0, because the registered `RtData` is 0.
- Reset asserted mid-stall or mid-flush clears state immediately, without waiting for a clock edge. The first load after reset follows the first rising edge with `Reset` low.
- Stall held for N cycles: outputs stay bit-identical for N cycles. A taken branch held in MEM under stall is counted once, on the edge where `Stall` is 0.
- Back-to-back taken branches without an intervening flush count once each.

## Test plan
- **Reset during activity**: apply `Reset` mid-stream → all outputs 0 asynchronously, before the next edge; `TakenCount` = 0.
- **Byte store**: `EX_ALUResult`=0x1003, `EX_MemSize`=10, `EX_MemWrite`=1, `EX_RtData`=0xAABBCCDD, `EX_Valid`=1 → next cycle `MEM_ByteEn`=1000, `MEM_StoreData`=0xDDDDDDDD, `MEM_Misaligned`=0.
- **Misaligned load**: word load at 0x1002 with `EX_RegWrite`=1 → `MEM_Misaligned`=1, `MEM_MemRead`=0, `MEM_RegWrite`=0, `MEM_ByteEn`=0000.
- **Stall then flush**:
  - Load `EX_Branch`=1, `EX_Zero`=1 → `MEM_PCSrc`=1.
  - Hold `Stall` for 3 cycles → `MEM_PCSrc` stays 1 and `TakenCount` stays 0.
  - Release `Stall` → `TakenCount`=1.
  - Assert `Flush` together with `Stall` → next cycle `MEM_Valid`=0 and `MEM_PCSrc`=0.
- **Not-taken branch**: `EX_Branch`=1, `EX_Zero`=0 → `MEM_PCSrc`=0; `TakenCount` unchanged.
- **Counter saturation**: with `TAKEN_CNT_W`=4, apply 17 taken branches → `TakenCount`=15; it does not wrap to 0.
